// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: binary-to-BCD FND scan controller.
// Accepts one unsigned value via valid/ready, converts it to BCD with a
// sequential double-dabble engine (one shift-and-add-3 iteration per clock),
// then commits it atomically to a display register. That register is scanned
// onto NUM_DIGITS common-anode digits at SCAN_HZ.
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   load_valid/load_data   value offer; accepted when load_ready is high
//   load_ready             converter idle
//   dp_mask                live per-digit decimal point enables
//   fndCom                 active-low one-cold digit enables (bit 0 = LSD)
//   fndFont                active-low segments {dp,g,f,e,d,c,b,a}
// Build option: define FND_LZB_EN to blank leading zero digits.
module fnd_scan_ctrl #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCAN_HZ    = 1_000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  load_ready,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] fndCom,
    output logic [7:0]            fndFont
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int unsigned DIV       = CLK_HZ / SCAN_HZ;
    localparam int unsigned DIV_W     = $clog2(DIV);
    localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
    localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W     = $clog2(DATA_W + 1);
    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t              state_q, state_d;
    logic                accept_c, conv_en_c, commit_c;
    logic [DATA_W-1:0]   bin_q;
    logic [BCD_W-1:0]    bcd_q, bcd_adj_c;
    logic [CNT_W-1:0]    iter_q;
    logic                ovf_q;
    logic [BCD_W-1:0]    disp_bcd_q;
    logic                disp_ovf_q;
    logic [DIV_W-1:0]    div_q;
    logic [IDX_W-1:0]    idx_q;
    logic                tick_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [3:0]          cur_digit_c;
    logic                cur_dp_c, cur_blank_c;
    logic [7:0]          font_c;
    logic [NUM_DIGITS-1:0] com_c;

    // Converter state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Converter next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (load_valid) state_d = S_CONV;
            S_CONV:   if (iter_q == CNT_W'(DATA_W - 1)) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Converter outputs and datapath strobes
    always_comb begin
        load_ready = (state_q == S_IDLE);
        accept_c   = load_ready && load_valid;
        conv_en_c  = (state_q == S_CONV);
        commit_c   = (state_q == S_COMMIT);
    end

    // Double-dabble correction: add 3 to every BCD digit >= 5 before shifting
    always_comb begin
        bcd_adj_c = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath and display register (updated only on commit)
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            ovf_q      <= 1'b0;
            disp_bcd_q <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            if (accept_c) begin
                bin_q  <= load_data;
                bcd_q  <= '0;
                iter_q <= '0;
                ovf_q  <= (64'(load_data) >= OVF_LIMIT);
            end else if (conv_en_c) begin
                bcd_q  <= {bcd_adj_c[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_q  <= {bin_q[DATA_W-2:0], 1'b0};
                iter_q <= iter_q + CNT_W'(1);
            end
            if (commit_c) begin
                disp_bcd_q <= bcd_q;
                disp_ovf_q <= ovf_q;
            end
        end
    end

    assign tick_c = (div_q == DIV_W'(DIV - 1));

    // Scan divider and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Leading-zero blanking mask; digit 0 and overflow dashes are never blanked
`ifdef FND_LZB_EN
    logic seen_nz_c;
    always_comb begin
        blank_c   = '0;
        seen_nz_c = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (disp_bcd_q[4*i +: 4] != 4'd0) seen_nz_c = 1'b1;
            blank_c[i] = !seen_nz_c && !disp_ovf_q;
        end
    end
`else
    always_comb begin
        blank_c = '0;
    end
`endif

    // Segment and digit-enable selection for the current scan position
    always_comb begin
        cur_digit_c = 4'd0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit_c = disp_bcd_q[4*i +: 4];
                cur_dp_c    = dp_mask[i];
                cur_blank_c = blank_c[i];
            end
        end
        unique case (cur_digit_c)
            4'd0:    font_c = 8'hC0;
            4'd1:    font_c = 8'hF9;
            4'd2:    font_c = 8'hA4;
            4'd3:    font_c = 8'hB0;
            4'd4:    font_c = 8'h99;
            4'd5:    font_c = 8'h92;
            4'd6:    font_c = 8'h82;
            4'd7:    font_c = 8'hF8;
            4'd8:    font_c = 8'h80;
            4'd9:    font_c = 8'h90;
            default: font_c = 8'hFF;
        endcase
        if (disp_ovf_q)       font_c = 8'hBF;
        else if (cur_blank_c) font_c = 8'hFF;
        font_c[7] = font_c[7] & ~cur_dp_c;
        com_c = ~(NUM_DIGITS'(1) << idx_q);
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (reset) begin
            fndCom  <= ~NUM_DIGITS'(1);
            fndFont <= {~dp_mask[0], 7'h40};
        end else begin
            fndCom  <= com_c;
            fndFont <= font_c;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
module tb_fnd_scan_ctrl;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned SCAN_HZ = 125;
    localparam int unsigned N       = 4;
    localparam int unsigned DATA_W  = 14;
    localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;
    localparam int unsigned LIMIT   = 10000;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [N-1:0]      dp_mask;
    logic [N-1:0]      fndCom;
    logic [7:0]        fndFont;

    fnd_scan_ctrl #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIGITS(N), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .dp_mask(dp_mask), .fndCom(fndCom), .fndFont(fndFont)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    string       phase = "init";

    // Reference model: displayed value, scan position derived from elapsed cycles
    int unsigned ecnt = 0;
    int unsigned m_idx = 0;
    int unsigned m_val = 0;
    bit          m_ovf = 1'b0;
    bit          m_ready = 1'b1;
    int unsigned pend = 0;
    int unsigned commit_at = 0;
    bit          last_hs = 1'b0;
    logic [N-1:0] exp_com;
    logic [7:0]  exp_font;

    function automatic logic [7:0] font(input int unsigned val, input bit ovf,
                                        input int unsigned pos, input bit dp);
        logic [7:0]  f;
        int unsigned p;
        int unsigned d;
        p = 1;
        for (int unsigned j = 0; j < pos; j++) p = p * 10;
        d = (val / p) % 10;
        case (d)
            0: f = 8'hC0;  1: f = 8'hF9;  2: f = 8'hA4;  3: f = 8'hB0;  4: f = 8'h99;
            5: f = 8'h92;  6: f = 8'h82;  7: f = 8'hF8;  8: f = 8'h80;  default: f = 8'h90;
        endcase
`ifdef FND_LZB_EN
        if (pos > 0 && val < p) f = 8'hFF;
`endif
        if (ovf) f = 8'hBF;
        if (dp) f[7] = 1'b0;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // One clock: advance the model alongside the DUT and compare all outputs
    task automatic step();
        bit                hs;
        logic [DATA_W-1:0] d;
        int unsigned       pidx, pval;
        bit                povf;
        logic [N-1:0]      dpm;
        hs   = load_valid && m_ready;
        d    = load_data;
        pidx = m_idx;
        pval = m_val;
        povf = m_ovf;
        dpm  = dp_mask;
        @(posedge clk);
        #1;
        last_hs = 1'b0;
        if (reset) begin
            ecnt = 0; m_idx = 0; m_val = 0; m_ovf = 1'b0; m_ready = 1'b1;
            exp_com  = ~N'(1);
            exp_font = font(0, 1'b0, 0, dpm[0]);
        end else begin
            ecnt++;
            exp_com  = ~(N'(1) << pidx);
            exp_font = font(pval, povf, pidx, dpm[pidx]);
            if (hs) begin
                pend = int'(d); commit_at = ecnt + DATA_W + 1; m_ready = 1'b0; last_hs = 1'b1;
            end else if (!m_ready && ecnt == commit_at) begin
                m_val = pend; m_ovf = (pend >= LIMIT); m_ready = 1'b1;
            end
            m_idx = (ecnt / DIV) % N;
        end
        chk("fndCom", 32'(fndCom), 32'(exp_com));
        chk("fndFont", 32'(fndFont), 32'(exp_font));
        chk("load_ready", 32'(load_ready), 32'(m_ready));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Offer a value and hold valid until accepted, within a cycle budget
    task automatic offer(input int unsigned v);
        int unsigned budget;
        load_valid = 1'b1;
        load_data  = DATA_W'(v);
        budget = 0;
        do begin
            step();
            budget++;
        end while (!last_hs && budget < 60);
        chk("accept_budget", 32'(last_hs), 32'd1);
        load_valid = 1'b0;
    endtask

    initial begin
        int unsigned v, gap;
        reset = 1'b1; load_valid = 1'b0; load_data = '0; dp_mask = '0;
        phase = "reset";
        run(3);
        reset = 1'b0;
        phase = "release";
        run(DIV + 3);

        phase = "load1234";
        offer(1234);
        run(DATA_W + 2 + N * DIV);

        phase = "overflow";
        offer(10000);
        run(DATA_W + 2);
        dp_mask = 4'b0100;
        run(N * DIV);
        dp_mask = 4'b0000;

        phase = "load7";
        offer(7);
        run(DATA_W + 2 + N * DIV);

        phase = "busy_ignore";
        offer(42);
        run(3);
        offer(99);
        run(DATA_W + 2 + N * DIV);

        phase = "reset_mid_conv";
        offer(555);
        run(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(DATA_W + 2 + N * DIV);

        phase = "dp_reset";
        dp_mask = 4'b0001;
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(4);

        phase = "random";
        for (int k = 0; k < 25; k++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(LIMIT, (1 << DATA_W) - 1)
                                            : $urandom_range(0, LIMIT - 1);
            dp_mask = N'($urandom);
            offer(v);
            gap = $urandom_range(0, DATA_W + 10);
            for (int unsigned g = 0; g < gap; g++) begin
                load_valid = 1'($urandom);
                load_data  = DATA_W'($urandom);
                step();
            end
            load_valid = 1'b0;
            run(DATA_W + 2 + $urandom_range(0, N * DIV));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Parametrised successor to the four-digit FND controller. Accepts one unsigned binary value through a valid/ready handshake and converts it to BCD with a sequential double-dabble engine. It then multiplexes NUM_DIGITS common-anode digits at a fixed scan rate, with a per-digit decimal point and overflow indication. The block sits between the sensor/processing datapath and the board FND pins.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- SCAN_HZ, 1_000, digit-advance rate in Hz; CLK_HZ/SCAN_HZ must be ≥ 4
- NUM_DIGITS, 4, number of digits, legal range 2..8
- DATA_W, 14, input value width, legal range 4..27

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  new value offered
- load_data  in  DATA_W  unsigned binary value
- load_ready  out  1  converter idle, can accept
- dp_mask  in  NUM_DIGITS  bit i = 1 lights decimal point of digit i (sampled live, not with load)
- fndCom  out  NUM_DIGITS  digit enables, active-low one-cold, bit 0 = least-significant digit
- fndFont  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Converter FSM:
  - IDLE: load_ready = 1. Transfer occurs on load_valid && load_ready at a clock edge; the edge captures load_data.
  - CONV: runs DATA_W shift-and-add-3 iterations, one per clock, on a 4*NUM_DIGITS-bit BCD register.
  - COMMIT: one cycle. Copies BCD digits and the overflow flag into the display register atomically. Returns to IDLE.
- While the FSM is not in IDLE, load_ready = 0 and load_valid is ignored; offered data is neither queued nor dropped silently.
- Overflow: flagged at capture when load_data ≥ 10^NUM_DIGITS. Every digit then shows dash 8'hBF.
- Scan:
  - A divider counts 0..CLK_HZ/SCAN_HZ−1 and pulses a tick on the terminal count.
  - Each tick advances the digit index 0→NUM_DIGITS−1, wrapping to 0.
- Segment codes:
  - Digits 0–9 use 8'hC0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Blank is 8'hFF.
  - Decimal point clears bit 7, including on blank and dash digits (blank+dp = 8'h7F).
- The display register changes only in COMMIT. The scan never shows a partially converted value.

## Timing
- Reset values:
  - FSM = IDLE, load_ready = 1.
  - Divider = 0, digit index = 0.
  - Display register = all zero digits, overflow = 0.
  - fndCom = ~1 (digit 0 on), fndFont = 8'hC0, or 8'h40 if dp_mask[0] = 1.
- Reset mid-conversion aborts the conversion. The display returns to its reset value and the captured value is discarded.
- Latency: handshake edge N; CONV edges N+1..N+DATA_W; COMMIT at edge N+DATA_W+1, which updates the display register. load_ready is high again from the cycle after edge N+DATA_W+1.
- fndCom and fndFont are registered: they reflect index, display register and dp_mask one cycle after those change.
- A tick coinciding with COMMIT: both take effect. The new digit position shows new data one cycle later.
- Digit period is exactly CLK_HZ/SCAN_HZ cycles. Full refresh is NUM_DIGITS times that.

## Configuration
- FND_LZB_EN defined: leading-zero blanking.
  - Every zero digit above the most-significant nonzero digit shows 8'hFF.
  - Digit 0 is always shown.
  - Overflow dashes are never blanked.
- FND_LZB_EN undefined: all NUM_DIGITS digits are shown, including leading zeros.

## Test plan
- Reset, then release: fndCom = 4'b1110, fndFont = 8'hC0, load_ready = 1. After CLK_HZ/SCAN_HZ cycles, fndCom = 4'b1101.
- Load 1234 (NUM_DIGITS = 4, DATA_W = 14): load_ready low for exactly DATA_W+1 cycles. The scan then shows digits 4,3,2,1 with fonts 99, B0, A4, F9.
- Load 10000: all four digits show 8'hBF. With dp_mask = 4'b0100, digit 2 shows 8'h3F.
- Load 7 with FND_LZB_EN: digit 0 = F8, digits 1–3 = FF. Without the macro: digits 1–3 = C0.
- Offer 99 during CONV of 42: 99 is not accepted, the display shows 42. Hold valid: 99 is accepted at the first IDLE edge.
- Assert reset on the 5th CONV cycle of 555: outputs return to their reset values and 555 never appears.
